// File: rtl/regbank_mp.sv
`default_nettype none
// ============================================================================
// Module   : regbank_mp
// Purpose  : Parametrised multi-port register bank. It has one mask-driven
//            write port (one-hot or broadcast), two independent read ports
//            (registered or combinational, with optional write-through), and
//            a bulk-clear sequencer that rewrites every entry with CLR_VAL.
// Ports    : ck        - clock, rising edge
//            rn        - asynchronous active-low reset
//            inp       - write data
//            wen       - write mask, bit k writes entry k
//            sel1/sel2 - read selects; selects >= DEPTH read as 0
//            out1/out2 - read data
//            clr_req   - start bulk clear (sampled only in IDLE)
//            busy      - clear sequencer active, user writes discarded
//            clr_done  - one-cycle pulse when the clear is complete
//            wr_drop   - one-cycle pulse, a write was discarded while busy
// Revision : 1.0 - initial release
// ============================================================================
module regbank_mp #(
    parameter int               WIDTH   = 16,
    parameter int               DEPTH   = 16,
    parameter int               SELW    = 5,
    parameter bit               RD_REG  = 1'b1,
    parameter bit               BYPASS  = 1'b1,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             ck,
    input  logic             rn,
    input  logic [WIDTH-1:0] inp,
    input  logic [DEPTH-1:0] wen,
    input  logic [SELW-1:0]  sel1,
    input  logic [SELW-1:0]  sel2,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic             wr_drop
);

    localparam int               IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(DEPTH - 1);
    localparam logic [SELW:0]    DEPTH_EXT = (SELW + 1)'(DEPTH);
    // Forwarding only makes sense when the read is registered.
    localparam bit               FWD       = RD_REG && BYPASS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            state   <= ST_IDLE;
            idx     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Any write attempt during the clear is dropped as a whole.
            wr_drop <= busy && (|wen);
            if (state == ST_CLEAR && idx != IDX_LAST) begin
                idx <= idx + IDXW'(1);
            end else begin
                idx <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        clr_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write path: the sequencer owns the array while busy, so the user
    // mask is ignored and only entry idx is rewritten with CLR_VAL.
    // ------------------------------------------------------------------
    assign wdata = busy ? CLR_VAL : inp;

    always_comb begin
        we = '0;
        for (int k = 0; k < DEPTH; k++) begin
            we[k] = busy ? (idx == IDXW'(k)) : wen[k];
        end
    end

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (we[k]) begin
                    mem[k] <= wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path. Out-of-range selects read as 0 and never forward.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] read_port(input logic [SELW-1:0] s);
        logic             in_range;
        logic [IDXW-1:0]  ridx;
        logic [WIDTH-1:0] val;
        in_range = ({1'b0, s} < DEPTH_EXT);
        ridx     = s[IDXW-1:0];
        val      = '0;
        if (in_range) begin
            val = mem[ridx];
            if (FWD && we[ridx]) begin
                val = wdata;
            end
        end
        return val;
    endfunction

    always_comb begin
        rd1 = read_port(sel1);
        rd2 = read_port(sel2);
    end

    generate
        if (RD_REG) begin : g_rd_reg
            always_ff @(posedge ck or negedge rn) begin
                if (!rn) begin
                    out1 <= '0;
                    out2 <= '0;
                end else begin
                    out1 <= rd1;
                    out2 <= rd2;
                end
            end
        end else begin : g_rd_comb
            assign out1 = rd1;
            assign out2 = rd2;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regbank_mp.sv
`timescale 1ns/1ps
module tb_regbank_mp;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int SW = 5;
    localparam logic [W-1:0] CLR = 16'h0000;

    logic          ck      = 1'b0;
    logic          rn      = 1'b1;
    logic [W-1:0]  inp     = '0;
    logic [D-1:0]  wen     = '0;
    logic [SW-1:0] sel1    = '0;
    logic [SW-1:0] sel2    = '0;
    logic          clr_req = 1'b0;

    // Registered read with forwarding (default build)
    logic [W-1:0] out1, out2;
    logic         busy, clr_done, wr_drop;
    // Registered read without forwarding
    logic [W-1:0] nb_out1, nb_out2;
    logic         nb_busy, nb_clr_done, nb_wr_drop;
    // Combinational read
    logic [W-1:0] c_out1, c_out2;
    logic         c_busy, c_clr_done, c_wr_drop;

    regbank_mp #(.WIDTH(W), .DEPTH(D), .SELW(SW), .RD_REG(1'b1), .BYPASS(1'b1), .CLR_VAL(CLR)) dut (
        .ck(ck), .rn(rn), .inp(inp), .wen(wen), .sel1(sel1), .sel2(sel2),
        .out1(out1), .out2(out2), .clr_req(clr_req),
        .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    regbank_mp #(.WIDTH(W), .DEPTH(D), .SELW(SW), .RD_REG(1'b1), .BYPASS(1'b0), .CLR_VAL(CLR)) dut_nb (
        .ck(ck), .rn(rn), .inp(inp), .wen(wen), .sel1(sel1), .sel2(sel2),
        .out1(nb_out1), .out2(nb_out2), .clr_req(clr_req),
        .busy(nb_busy), .clr_done(nb_clr_done), .wr_drop(nb_wr_drop)
    );

    regbank_mp #(.WIDTH(W), .DEPTH(D), .SELW(SW), .RD_REG(1'b0), .BYPASS(1'b1), .CLR_VAL(CLR)) dut_c (
        .ck(ck), .rn(rn), .inp(inp), .wen(wen), .sel1(sel1), .sel2(sel2),
        .out1(c_out1), .out2(c_out2), .clr_req(clr_req),
        .busy(c_busy), .clr_done(c_clr_done), .wr_drop(c_wr_drop)
    );

    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // e1/e2: forwarding build after the edge; n1/n2: pre-write value, seen
    // by the non-forwarding build after the edge and by the comb build before it.
    typedef struct {
        logic [D-1:0]  wen;
        logic [W-1:0]  inp;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        logic [W-1:0]  e1;
        logic [W-1:0]  e2;
        logic [W-1:0]  n1;
        logic [W-1:0]  n2;
    } vec_t;

    typedef struct {
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [W-1:0] n1;
        logic [W-1:0] n2;
        string        tag;
    } exp_t;

    exp_t sbq[$];

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge ck);
        wen  = v.wen;
        inp  = v.inp;
        sel1 = v.s1;
        sel2 = v.s2;
        e.e1 = v.e1; e.e2 = v.e2; e.n1 = v.n1; e.n2 = v.n2; e.tag = tag;
        sbq.push_back(e);
        #1;
        check($sformatf("%s comb out1", tag), c_out1, v.n1);
        check($sformatf("%s comb out2", tag), c_out2, v.n2);
        @(posedge ck);
        #1;
        wen = '0;
        if (sbq.size() == 0) begin
            check($sformatf("%s scoreboard empty", tag), 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check($sformatf("%s byp out1", e.tag), out1, e.e1);
            check($sformatf("%s byp out2", e.tag), out2, e.e2);
            check($sformatf("%s nobyp out1", e.tag), nb_out1, e.n1);
            check($sformatf("%s nobyp out2", e.tag), nb_out2, e.n2);
        end
    endtask

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int drops;
        int done_seen;
        logic [W-1:0] ev1;
        logic [W-1:0] ev2;

        //            wen       inp       s1     s2     e1        e2        n1        n2
        tbl[0]  = '{16'h0010, 16'habcd, 5'd4,  5'd0,  16'habcd, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{16'h0000, 16'h0000, 5'd4,  5'd0,  16'habcd, 16'h0000, 16'habcd, 16'h0000};
        tbl[2]  = '{16'h8001, 16'h1234, 5'd0,  5'd15, 16'h1234, 16'h1234, 16'h0000, 16'h0000};
        tbl[3]  = '{16'h0000, 16'h0000, 5'd0,  5'd15, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        tbl[4]  = '{16'h0000, 16'h0000, 5'd1,  5'd14, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[5]  = '{16'h0000, 16'h0000, 5'd7,  5'd4,  16'h0000, 16'habcd, 16'h0000, 16'habcd};
        tbl[6]  = '{16'h0008, 16'h5a5a, 5'd3,  5'd3,  16'h5a5a, 16'h5a5a, 16'h0000, 16'h0000};
        tbl[7]  = '{16'h0000, 16'h0000, 5'd3,  5'd4,  16'h5a5a, 16'habcd, 16'h5a5a, 16'habcd};
        tbl[8]  = '{16'hffff, 16'hffff, 5'd20, 5'd9,  16'h0000, 16'hffff, 16'h0000, 16'h0000};
        tbl[9]  = '{16'h0000, 16'h0000, 5'd20, 5'd31, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[10] = '{16'h0000, 16'h0000, 5'd16, 5'd15, 16'h0000, 16'hffff, 16'h0000, 16'hffff};
        tbl[11] = '{16'h0000, 16'h0000, 5'd2,  5'd2,  16'hffff, 16'hffff, 16'hffff, 16'hffff};
        tbl[12] = '{16'h0004, 16'h0f0f, 5'd2,  5'd5,  16'h0f0f, 16'hffff, 16'hffff, 16'hffff};
        tbl[13] = '{16'h0000, 16'h0000, 5'd2,  5'd31, 16'h0f0f, 16'h0000, 16'h0f0f, 16'h0000};

        // Reset
        #1 rn = 1'b0;
        #9;
        check("reset out1", out1, 16'h0);
        check("reset out2", out2, 16'h0);
        check("reset busy", busy, 1'b0);
        check("reset clr_done", clr_done, 1'b0);
        check("reset wr_drop", wr_drop, 1'b0);
        check("reset nobyp out1", nb_out1, 16'h0);
        check("reset comb out1", c_out1, 16'h0);
        check("reset flags others", {nb_busy, nb_clr_done, nb_wr_drop, c_busy, c_clr_done, c_wr_drop}, 32'd0);
        #1 rn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Bulk clear: fill with beef, request a clear, poke it while busy
        apply('{16'hffff, 16'hbeef, 5'd0, 5'd2, 16'hbeef, 16'hbeef, 16'hffff, 16'h0f0f}, "fill1");
        @(negedge ck);
        clr_req = 1'b1;
        @(posedge ck);
        #1 clr_req = 1'b0;
        @(negedge ck);
        check("busy after clr_req", busy, 1'b1);
        nb = 0;
        drops = 0;
        while (busy && nb < 40) begin
            nb++;
            if (wr_drop) drops++;
            if (nb == 6) check("wr_drop after busy write", wr_drop, 1'b1);
            wen     = (nb == 5) ? 16'h0002 : 16'h0000;
            inp     = 16'h1111;
            clr_req = (nb == 10);
            if (nb == 8) begin
                sel1 = 5'd3;
                sel2 = 5'd12;
            end
            @(posedge ck);
            #1;
            if (nb == 8) begin
                check("mid-clear read cleared entry", out1, CLR);
                check("mid-clear read pending entry", out2, 16'hbeef);
                check("mid-clear nobyp pending entry", nb_out2, 16'hbeef);
            end
            @(negedge ck);
        end
        clr_req = 1'b0;
        check("busy cycle count", nb, 32'd16);
        check("clr_done pulse", clr_done, 1'b1);
        if (wr_drop) drops++;
        check("wr_drop pulse count", drops, 32'd1);
        // DONE cycle: user write accepted, clr_req ignored
        wen     = 16'h0040;
        inp     = 16'h7777;
        clr_req = 1'b1;
        @(posedge ck);
        #1;
        wen     = '0;
        clr_req = 1'b0;
        @(negedge ck);
        check("clr_done one cycle", clr_done, 1'b0);
        check("clr_req in DONE ignored", busy, 1'b0);
        check("no wr_drop in DONE", wr_drop, 1'b0);

        for (int k = 0; k < D; k++) begin
            ev1 = (k == 6) ? 16'h7777 : CLR;
            ev2 = ((D - 1 - k) == 6) ? 16'h7777 : CLR;
            apply('{16'h0000, 16'h0000, SW'(k), SW'(D - 1 - k), ev1, ev2, ev1, ev2},
                  $sformatf("clr_rd%0d", k));
        end

        // Reset in the middle of a clear
        apply('{16'hffff, 16'hbeef, 5'd6, 5'd1, 16'hbeef, 16'hbeef, 16'h7777, CLR}, "fill2");
        @(negedge ck);
        clr_req = 1'b1;
        @(posedge ck);
        #1 clr_req = 1'b0;
        @(negedge ck);
        nb = 0;
        while (busy && nb < 7) begin
            nb++;
            if (nb < 7) @(negedge ck);
        end
        check("busy cycles before abort", nb, 32'd7);
        rn = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort out1", out1, 16'h0);
        check("abort out2", out2, 16'h0);
        check("abort nobyp out1", nb_out1, 16'h0);
        check("abort comb out1", c_out1, 16'h0);
        @(negedge ck);
        rn = 1'b1;
        done_seen = 0;
        repeat (4) begin
            @(negedge ck);
            if (clr_done) done_seen++;
        end
        check("no clr_done after abort", done_seen, 32'd0);
        for (int k = 0; k < D; k++) begin
            apply('{16'h0000, 16'h0000, SW'(k), SW'(D - 1 - k), 16'h0, 16'h0, 16'h0, 16'h0},
                  $sformatf("abort_rd%0d", k));
        end

        // Fresh clear after the abort runs to completion
        @(negedge ck);
        clr_req = 1'b1;
        @(posedge ck);
        #1 clr_req = 1'b0;
        @(negedge ck);
        nb = 0;
        while (busy && nb < 40) begin
            nb++;
            @(negedge ck);
        end
        check("second clear busy cycles", nb, 32'd16);
        check("second clear clr_done", clr_done, 1'b1);
        @(negedge ck);
        check("second clear idle", {busy, clr_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
Parametrised successor of the 16x16 register bank. Provides one mask-driven write port (one-hot or broadcast) and two read ports. Read ports are registered or combinational, with optional write-through bypass. A hardware bulk-clear sequencer re-initialises all entries without a reset. Sits between the datapath lanes and the VLIW/SIMD operand select logic.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 16, number of entries (>=2)
SELW, 5, read select width; must satisfy 2**SELW >= DEPTH
RD_REG, 1, 1 = registered read (latency 1), 0 = combinational read
BYPASS, 1, 1 = write-through forwarding on registered reads (ignored when RD_REG=0)
CLR_VAL, 0, value written to every entry by the clear sequencer

Ports:
ck  in  1  clock, rising edge
rn  in  1  asynchronous active-low reset
inp  in  WIDTH  write data
wen  in  DEPTH  write mask, bit k writes entry k; multiple bits set = broadcast
sel1  in  SELW  read select, port 1
sel2  in  SELW  read select, port 2
out1  out  WIDTH  read data, port 1
out2  out  WIDTH  read data, port 2
clr_req  in  1  start bulk clear (single-cycle pulse or level; sampled only in IDLE)
busy  out  1  clear sequencer active
clr_done  out  1  one-cycle pulse, clear complete
wr_drop  out  1  one-cycle pulse, a write was discarded because busy=1

Behaviour:
- Reset (rn=0, async): all entries, out1, out2, busy, clr_done and wr_drop go to 0. FSM goes to IDLE, clear index to 0. Release is synchronous to the next ck edge.
- Write: at a rising ck edge with busy=0, every entry k with wen[k]=1 takes inp. wen=0 means no write.
- Read select: sel < DEPTH returns entry[sel]. sel >= DEPTH returns constant 0 and never bypasses.
- RD_REG=0: out = entry[sel] combinationally. A same-cycle write is visible only after the edge.
- RD_REG=1, BYPASS=0: out registers entry[sel] at the edge, giving the pre-write value when sel is written the same cycle.
- RD_REG=1, BYPASS=1: if the entry selected by sel is written at this edge (by user or clear), out registers the new data. Otherwise it registers the stored value.
- Both ports are independent. sel1 == sel2 is legal and yields identical data.
- FSM states:
  - IDLE: busy=0. clr_req=1 -> CLEAR with idx=0. A user write in the same cycle as clr_req still commits.
  - CLEAR: busy=1. Each cycle writes CLR_VAL to entry idx, then idx++. When idx == DEPTH-1 -> DONE.
  - DONE: busy=0, clr_done=1 for exactly one cycle, user writes accepted again -> IDLE.
- Clear timing: clr_req sampled at edge E0. busy is high for cycles E0+1 .. E0+DEPTH. clr_done is high in cycle E0+DEPTH+1.
- Writes while busy=1: the whole mask is discarded, and wr_drop pulses in the following cycle. Reads stay active during clear and return the partially cleared contents.
- clr_req while busy or in DONE: ignored. No re-queue, no error.
- Reset mid-clear: aborts immediately. No clr_done pulse, all entries 0.
- No other arithmetic. idx is $clog2(DEPTH) bits and never wraps past DEPTH-1.

Test Plan:
- Reset then basic write/read: rn low 10ns, release. wen=16'h0010, inp=16'habcd, then sel1=4 -> out1=16'habcd (1 cycle later if RD_REG=1). sel2=0 -> out2=0.
- Broadcast: wen=16'h8001, inp=16'h1234 -> sel1=0 and sel2=15 both read 16'h1234. Entries 1..14 stay 0.
- Bypass/no-bypass: RD_REG=1, sel1=3, wen=16'h0008, inp=16'h5a5a in the same cycle. BYPASS=1 -> out1=16'h5a5a next cycle. BYPASS=0 -> out1 shows the old value, then 16'h5a5a a cycle later.
- Out-of-range select: sel1=5'd20 after writing all entries to 16'hffff -> out1=0.
- Bulk clear: fill all entries with 16'hbeef, pulse clr_req. busy is high for 16 cycles, then clr_done pulses once. All entries read CLR_VAL. A wen=16'h0002 issued at busy cycle 5 -> wr_drop pulses and entry 1 equals CLR_VAL.
- Reset mid-clear: assert rn=0 at busy cycle 7 -> busy=0 immediately, no clr_done, all reads 0. A new clr_req after release completes normally.
